// File: rtl/memory_responder_pkg.sv
// Shared bus codes, FSM state encoding and the boot image written during reset.
package memory_responder_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h7;
  localparam logic [3:0] OP_STORE = 4'hB;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WR   = 2'd2,
    MEM_LD   = 2'd3
  } mem_state_e;

  // Which registered source currently drives MBR_in.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_ERR  = 2'd2
  } mbr_src_e;

  localparam logic [7:0]  PL_LOAD_ADDR  = 8'd20;
  localparam logic [7:0]  PL_ADD_ADDR   = 8'd21;
  localparam logic [7:0]  PL_STORE_ADDR = 8'd22;
  localparam logic [7:0]  PL_X_ADDR     = 8'h80;
  localparam logic [7:0]  PL_Y_ADDR     = 8'h81;
  localparam logic [15:0] PL_LOAD_INSN  = {OP_LOAD,  12'h180};
  localparam logic [15:0] PL_ADD_INSN   = {OP_ADD,   12'h181};
  localparam logic [15:0] PL_STORE_INSN = {OP_STORE, 12'h182};
  localparam logic [15:0] PL_X_VAL      = 16'd5;
  localparam logic [15:0] PL_Y_VAL      = 16'd7;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/memory_responder_word_ram.sv
// DEPTH x 16 word array: one synchronous write port, registered read port, no reset.
// The boot image is written on every clock edge while init is high.
module memory_responder_word_ram
  import memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          init,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (init) begin
      if (32'(PL_LOAD_ADDR)  < DEPTH) mem[PL_LOAD_ADDR[AW-1:0]]  <= PL_LOAD_INSN;
      if (32'(PL_ADD_ADDR)   < DEPTH) mem[PL_ADD_ADDR[AW-1:0]]   <= PL_ADD_INSN;
      if (32'(PL_STORE_ADDR) < DEPTH) mem[PL_STORE_ADDR[AW-1:0]] <= PL_STORE_INSN;
      if (32'(PL_X_ADDR)     < DEPTH) mem[PL_X_ADDR[AW-1:0]]     <= PL_X_VAL;
      if (32'(PL_Y_ADDR)     < DEPTH) mem[PL_Y_ADDR[AW-1:0]]     <= PL_Y_VAL;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/memory_responder.sv
// Zero-wait-state memory target for the CPU MAR/MBR bus, with a side loader port,
// saturating access counters and a sticky address-error flag.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter bit          PRELOAD  = 1'b1,
  parameter logic [15:0] ERR_WORD = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  MAR,
  input  logic [15:0] MBR_out,
  output logic [15:0] MBR_in,
  input  logic        Mem_EN,
  input  logic        Mem_CS,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic [1:0]  mem_state,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        addr_err
);

  localparam int unsigned AW = addr_width(DEPTH);

  mem_state_e    state;
  mbr_src_e      mbr_src;
  logic          rd_req, wr_req, ld_req;
  logic          cpu_ok, ld_ok;
  logic          ram_init, ram_we, ram_re;
  logic [AW-1:0] ram_waddr;
  logic [15:0]   ram_wdata, ram_rdata;

  assign rd_req   = Mem_EN & (Mem_CS == MEM_READ);
  assign wr_req   = Mem_EN & (Mem_CS == MEM_WRITE);
  assign ld_req   = ~Mem_EN & ld_valid;
  assign ld_ready = ~Mem_EN;

  assign cpu_ok = 32'(MAR) < DEPTH;
  assign ld_ok  = 32'(ld_addr) < DEPTH;

  // Reset gates every array access so an in-flight write is dropped.
  assign ram_init  = PRELOAD & ~rst_n;
  assign ram_we    = rst_n & ((wr_req & cpu_ok) | (ld_req & ld_ok));
  assign ram_re    = rst_n & rd_req & cpu_ok;
  assign ram_waddr = Mem_EN ? MAR[AW-1:0] : ld_addr[AW-1:0];
  assign ram_wdata = Mem_EN ? MBR_out : ld_data;

  memory_responder_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .init  (ram_init),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (MAR[AW-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MEM_IDLE;
      mbr_src  <= SRC_ZERO;
      rd_count <= '0;
      wr_count <= '0;
      addr_err <= 1'b0;
    end else if (rd_req) begin
      state   <= MEM_RD;
      mbr_src <= cpu_ok ? SRC_RAM : SRC_ERR;
      if (rd_count != '1) rd_count <= rd_count + 1'b1;
      if (!cpu_ok) addr_err <= 1'b1;
    end else if (wr_req) begin
      state <= MEM_WR;
      if (wr_count != '1) wr_count <= wr_count + 1'b1;
      if (!cpu_ok) addr_err <= 1'b1;
    end else if (ld_req) begin
      state <= MEM_LD;
      if (!ld_ok) addr_err <= 1'b1;
    end else begin
      state <= MEM_IDLE;
    end
  end

  // MBR_in is a select between registered sources: the RAM read register only
  // loads on in-range reads, so it holds across writes, loads and idle cycles.
  always_comb begin
    MBR_in = '0;
    unique case (mbr_src)
      SRC_RAM: MBR_in = ram_rdata;
      SRC_ERR: MBR_in = ERR_WORD;
      default: MBR_in = '0;
    endcase
  end

  assign mem_state = state;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: a 256-word and a 128-word instance share
// the same stimulus and are compared against a behavioural model of the bus rules.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Mem_EN, Mem_CS, ld_valid;
  logic [7:0]  MAR, ld_addr;
  logic [15:0] MBR_out, ld_data;

  logic [15:0] mbr_o [2];
  logic        ld_rdy [2];
  logic [1:0]  st_o [2];
  logic [15:0] rdc [2];
  logic [15:0] wrc [2];
  logic        aerr [2];

  int unsigned depth [2] = '{256, 128};
  logic [15:0] m_mem [2][256];
  logic [15:0] m_mbr [2];
  logic [1:0]  m_st [2];
  logic [15:0] m_rd [2];
  logic [15:0] m_wr [2];
  logic        m_err [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_responder #(.DEPTH(256), .PRELOAD(1'b1), .ERR_WORD(16'hDEAD)) dut (
    .clk(clk), .rst_n(rst_n), .MAR(MAR), .MBR_out(MBR_out), .MBR_in(mbr_o[0]),
    .Mem_EN(Mem_EN), .Mem_CS(Mem_CS), .ld_valid(ld_valid), .ld_ready(ld_rdy[0]),
    .ld_addr(ld_addr), .ld_data(ld_data), .mem_state(st_o[0]), .rd_count(rdc[0]),
    .wr_count(wrc[0]), .addr_err(aerr[0])
  );

  memory_responder #(.DEPTH(128), .PRELOAD(1'b1), .ERR_WORD(16'hDEAD)) dut128 (
    .clk(clk), .rst_n(rst_n), .MAR(MAR), .MBR_out(MBR_out), .MBR_in(mbr_o[1]),
    .Mem_EN(Mem_EN), .Mem_CS(Mem_CS), .ld_valid(ld_valid), .ld_ready(ld_rdy[1]),
    .ld_addr(ld_addr), .ld_data(ld_data), .mem_state(st_o[1]), .rd_count(rdc[1]),
    .wr_count(wrc[1]), .addr_err(aerr[1])
  );

  // Reference: what one rising edge does to each memory given the current bus.
  task automatic model_edge();
    logic inr;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_mbr[d] = 16'h0000; m_st[d] = 2'd0; m_rd[d] = 16'd0; m_wr[d] = 16'd0; m_err[d] = 1'b0;
        m_mem[d][20] = 16'h3180; m_mem[d][21] = 16'h7181; m_mem[d][22] = 16'hB182;
        if (depth[d] > 32'h80) m_mem[d][8'h80] = 16'd5;
        if (depth[d] > 32'h81) m_mem[d][8'h81] = 16'd7;
      end else if (Mem_EN) begin
        inr = int'(MAR) < int'(depth[d]);
        if (!Mem_CS) begin
          m_st[d]  = 2'd1;
          m_mbr[d] = inr ? m_mem[d][MAR] : 16'hDEAD;
          if (m_rd[d] != 16'hFFFF) m_rd[d] = m_rd[d] + 16'd1;
        end else begin
          m_st[d] = 2'd2;
          if (inr) m_mem[d][MAR] = MBR_out;
          if (m_wr[d] != 16'hFFFF) m_wr[d] = m_wr[d] + 16'd1;
        end
        if (!inr) m_err[d] = 1'b1;
      end else if (ld_valid) begin
        m_st[d] = 2'd3;
        if (int'(ld_addr) < int'(depth[d])) m_mem[d][ld_addr] = ld_data;
        else m_err[d] = 1'b1;
      end else begin
        m_st[d] = 2'd0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    Mem_EN = 1'b0; Mem_CS = 1'b0; ld_valid = 1'b0;
    MAR = 8'h00; MBR_out = 16'h0000; ld_addr = 8'h00; ld_data = 16'h0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; set_idle(); tick(); tick(); rst_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [7:0] a);
    MAR = a; Mem_EN = 1'b1; Mem_CS = 1'b0; ld_valid = 1'b0; tick();
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [15:0] v);
    MAR = a; MBR_out = v; Mem_EN = 1'b1; Mem_CS = 1'b1; ld_valid = 1'b0; tick();
  endtask

  task automatic load_word(input logic [7:0] a, input logic [15:0] v);
    Mem_EN = 1'b0; ld_valid = 1'b1; ld_addr = a; ld_data = v; tick(); ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; set_idle(); tick(); tick();
    for (int d = 0; d < 2; d++) begin
      total += 5;
      if (mbr_o[d] !== 16'h0000) begin bad++; $display("FAIL reset_mbr dut%0d got %h want 0000", d, mbr_o[d]); end
      if (st_o[d] !== 2'd0) begin bad++; $display("FAIL reset_state dut%0d got %0d want 0", d, st_o[d]); end
      if (rdc[d] !== 16'd0) begin bad++; $display("FAIL reset_rd dut%0d got %0d want 0", d, rdc[d]); end
      if (wrc[d] !== 16'd0) begin bad++; $display("FAIL reset_wr dut%0d got %0d want 0", d, wrc[d]); end
      if (aerr[d] !== 1'b0) begin bad++; $display("FAIL reset_err dut%0d got %b want 0", d, aerr[d]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_preload();
    logic [7:0]  pa [5] = '{8'd20, 8'd21, 8'd22, 8'h80, 8'h81};
    logic [15:0] pv [5] = '{16'h3180, 16'h7181, 16'hB182, 16'h0005, 16'h0007};
    for (int i = 0; i < 5; i++) begin
      cpu_read(pa[i]);
      total++;
      if (mbr_o[0] !== pv[i]) begin bad++; $display("FAIL preload dut0 addr %h got %h want %h", pa[i], mbr_o[0], pv[i]); end
      total++;
      if (mbr_o[1] !== m_mbr[1]) begin bad++; $display("FAIL preload dut1 addr %h got %h want %h", pa[i], mbr_o[1], m_mbr[1]); end
    end
    set_idle(); tick();
    total += 2;
    if (rdc[0] !== 16'd5) begin bad++; $display("FAIL preload_rd dut0 got %0d want 5", rdc[0]); end
    if (aerr[1] !== 1'b1) begin bad++; $display("FAIL preload_err dut1 got %b want 1", aerr[1]); end
  endtask

  task automatic test_write_read();
    logic [15:0] prev;
    prev = mbr_o[0];
    cpu_write(8'h82, 16'h000C);
    total += 2;
    if (st_o[0] !== 2'd2) begin bad++; $display("FAIL wr_state dut0 got %0d want 2", st_o[0]); end
    if (mbr_o[0] !== prev) begin bad++; $display("FAIL wr_hold dut0 got %h want %h", mbr_o[0], prev); end
    cpu_read(8'h82);
    for (int d = 0; d < 2; d++) begin
      total += 3;
      if (mbr_o[d] !== m_mbr[d]) begin bad++; $display("FAIL wr_rd_data dut%0d got %h want %h", d, mbr_o[d], m_mbr[d]); end
      if (st_o[d] !== 2'd1) begin bad++; $display("FAIL wr_rd_state dut%0d got %0d want 1", d, st_o[d]); end
      if (wrc[d] !== 16'd1) begin bad++; $display("FAIL wr_count dut%0d got %0d want 1", d, wrc[d]); end
    end
    total++;
    if (mbr_o[0] !== 16'h000C) begin bad++; $display("FAIL wr_rd_value dut0 got %h want 000C", mbr_o[0]); end
    set_idle(); tick();
  endtask

  task automatic test_loader();
    load_word(8'h40, 16'h5555);
    ld_valid = 1'b1; ld_addr = 8'h40; ld_data = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      MAR = 8'h40; Mem_EN = 1'b1; Mem_CS = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
        total++;
        if (ld_rdy[d] !== 1'b0) begin bad++; $display("FAIL ld_blocked dut%0d got %b want 0", d, ld_rdy[d]); end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (mbr_o[d] !== 16'h5555) begin bad++; $display("FAIL ld_no_load dut%0d got %h want 5555", d, mbr_o[d]); end
      end
    end
    Mem_EN = 1'b0;
    #1;
    total++;
    if (ld_rdy[0] !== 1'b1) begin bad++; $display("FAIL ld_ready dut0 got %b want 1", ld_rdy[0]); end
    tick();
    total++;
    if (st_o[0] !== 2'd3) begin bad++; $display("FAIL ld_state dut0 got %0d want 3", st_o[0]); end
    ld_valid = 1'b0;
    cpu_read(8'h40);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (mbr_o[d] !== 16'h1234) begin bad++; $display("FAIL ld_readback dut%0d got %h want 1234", d, mbr_o[d]); end
    end
    set_idle(); tick();
  endtask

  task automatic test_out_of_range();
    do_reset();
    load_word(8'h7F, 16'h7777);
    cpu_read(8'h7F);
    total += 2;
    if (mbr_o[1] !== 16'h7777) begin bad++; $display("FAIL oor_last_word dut1 got %h want 7777", mbr_o[1]); end
    if (aerr[1] !== 1'b0) begin bad++; $display("FAIL oor_last_err dut1 got %b want 0", aerr[1]); end
    cpu_read(8'hC0);
    total += 3;
    if (mbr_o[1] !== 16'hDEAD) begin bad++; $display("FAIL oor_read dut1 got %h want DEAD", mbr_o[1]); end
    if (aerr[1] !== 1'b1) begin bad++; $display("FAIL oor_err dut1 got %b want 1", aerr[1]); end
    if (aerr[0] !== 1'b0) begin bad++; $display("FAIL oor_err dut0 got %b want 0", aerr[0]); end
    cpu_write(8'hC0, 16'hAAAA);
    cpu_read(8'h40);
    total++;
    if (mbr_o[1] !== 16'h1234) begin bad++; $display("FAIL oor_alias dut1 got %h want 1234", mbr_o[1]); end
    cpu_read(8'hC0);
    total += 3;
    if (mbr_o[0] !== 16'hAAAA) begin bad++; $display("FAIL oor_dut0_word got %h want AAAA", mbr_o[0]); end
    if (rdc[1] !== 16'd4) begin bad++; $display("FAIL oor_rd_count dut1 got %0d want 4", rdc[1]); end
    if (wrc[1] !== 16'd1) begin bad++; $display("FAIL oor_wr_count dut1 got %0d want 1", wrc[1]); end
    set_idle(); tick();
  endtask

  task automatic test_async_abort();
    MAR = 8'h82; MBR_out = 16'hBEEF; Mem_EN = 1'b1; Mem_CS = 1'b1;
    #6 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      total += 4;
      if (mbr_o[d] !== 16'h0000) begin bad++; $display("FAIL abort_mbr dut%0d got %h want 0000", d, mbr_o[d]); end
      if (rdc[d] !== 16'd0) begin bad++; $display("FAIL abort_rd dut%0d got %0d want 0", d, rdc[d]); end
      if (wrc[d] !== 16'd0) begin bad++; $display("FAIL abort_wr dut%0d got %0d want 0", d, wrc[d]); end
      if (aerr[d] !== 1'b0) begin bad++; $display("FAIL abort_err dut%0d got %b want 0", d, aerr[d]); end
    end
    tick(); tick();
    rst_n = 1'b1; set_idle();
    cpu_read(8'h82);
    total += 2;
    if (mbr_o[0] !== 16'h000C) begin bad++; $display("FAIL abort_word dut0 got %h want 000C", mbr_o[0]); end
    if (mbr_o[1] !== m_mbr[1]) begin bad++; $display("FAIL abort_word dut1 got %h want %h", mbr_o[1], m_mbr[1]); end
    set_idle(); tick();
  endtask

  task automatic test_program();
    logic [15:0] pc, ir, acc;
    do_reset();
    pc = 16'd20; acc = 16'd0;
    for (int n = 0; n < 3; n++) begin
      cpu_read(pc[7:0]);
      ir = mbr_o[0];
      case (ir[15:12])
        4'h3: begin cpu_read(ir[7:0]); acc = mbr_o[0]; end
        4'h7: begin cpu_read(ir[7:0]); acc = acc + mbr_o[0]; end
        4'hB: cpu_write(ir[7:0], acc);
        default: begin set_idle(); tick(); end
      endcase
      pc = pc + 16'd1;
    end
    set_idle(); tick();
    total += 2;
    if (rdc[0] !== 16'd5) begin bad++; $display("FAIL prog_rd dut0 got %0d want 5", rdc[0]); end
    if (wrc[0] !== 16'd1) begin bad++; $display("FAIL prog_wr dut0 got %0d want 1", wrc[0]); end
    cpu_read(8'h82);
    total++;
    if (mbr_o[0] !== 16'h000C) begin bad++; $display("FAIL prog_result dut0 got %h want 000C", mbr_o[0]); end
    set_idle(); tick();
  endtask

  task automatic test_random();
    logic [7:0] last;
    for (int a = 0; a < 256; a++) load_word(8'(a), 16'($urandom));
    last = 8'h00;
    repeat (400) begin
      Mem_EN   = ($urandom_range(0, 2) != 0);
      Mem_CS   = 1'($urandom);
      case ($urandom_range(0, 2))
        0: MAR = last;
        1: MAR = 8'($urandom_range(120, 135));
        default: MAR = 8'($urandom);
      endcase
      last     = MAR;
      MBR_out  = 16'($urandom);
      ld_valid = 1'($urandom);
      ld_addr  = 8'($urandom);
      ld_data  = 16'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        total++;
        if (ld_rdy[d] !== !Mem_EN) begin bad++; $display("FAIL rnd_ld_ready dut%0d got %b want %b", d, ld_rdy[d], !Mem_EN); end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        total += 5;
        if (mbr_o[d] !== m_mbr[d]) begin bad++; $display("FAIL rnd_mbr dut%0d got %h want %h", d, mbr_o[d], m_mbr[d]); end
        if (st_o[d] !== m_st[d]) begin bad++; $display("FAIL rnd_state dut%0d got %0d want %0d", d, st_o[d], m_st[d]); end
        if (rdc[d] !== m_rd[d]) begin bad++; $display("FAIL rnd_rd dut%0d got %0d want %0d", d, rdc[d], m_rd[d]); end
        if (wrc[d] !== m_wr[d]) begin bad++; $display("FAIL rnd_wr dut%0d got %0d want %0d", d, wrc[d], m_wr[d]); end
        if (aerr[d] !== m_err[d]) begin bad++; $display("FAIL rnd_err dut%0d got %b want %b", d, aerr[d], m_err[d]); end
      end
    end
    set_idle(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_preload();
    test_write_read();
    test_loader();
    test_out_of_range();
    test_async_abort();
    test_program();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
